obi_data_slice: RTL and testbench

Registered OBI slice between the CPU subsystem data port (core_data_req_o / core_data_resp_i) and the system bus. It breaks every combinational path between core and bus and buffers up to two requests, so a single transfer is never stalled by the slice. It also caps in-flight transactions so core-side response bookkeeping cannot overflow. Sits inside the MCU top, directly downstream of cpu_subsystem's data port, with no change to OBI semantics.

---
 rtl/core_v_mini_mcu_pkg.sv | 7 +
 rtl/obi_pkg.sv | 36 +++
 rtl/obi_req_fifo.sv | 70 +++++++
 rtl/obi_data_slice.sv | 104 ++++++++++
 tb/tb_obi_data_slice.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level defaults shared by the MCU top and its benches.
package core_v_mini_mcu_pkg;

    localparam int unsigned OBI_SLICE_REQ_DEPTH       = 32'd2;
    localparam int unsigned OBI_SLICE_MAX_OUTSTANDING = 32'd4;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the core, the bus and the data slice.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // What a buffered request needs to carry; req is implied by occupancy.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_payload_t;

    function automatic obi_req_t obi_issue(input obi_payload_t p);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = p.we;
        r.be    = p.be;
        r.addr  = p.addr;
        r.wdata = p.wdata;
        return r;
    endfunction

endpackage

// File: rtl/obi_req_fifo.sv
// Synchronous request FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module obi_req_fifo
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  obi_payload_t wdata_i,
    output obi_payload_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam int unsigned CW = $clog2(DEPTH + 32'd1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    obi_payload_t  r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 32'd1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign head_o  = r_mem[r_rd_ptr];

    // Storage; contents are only observed while occupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_data_slice.sv
// Registered OBI data slice: buffers requests, caps in-flight transactions
// and registers responses, so no path runs combinationally from bus to core.
module obi_data_slice
    import obi_pkg::*;
    import core_v_mini_mcu_pkg::*;
#(
    parameter int unsigned REQ_DEPTH       = OBI_SLICE_REQ_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = OBI_SLICE_MAX_OUTSTANDING,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 32'd1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  obi_req_t         core_req_i,
    output obi_resp_t        core_resp_o,
    output obi_req_t         bus_req_o,
    input  obi_resp_t        bus_resp_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             stray_rvalid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic             r_stray;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_core_gnt;
    logic             w_core_hs;
    logic             w_bus_hs;
    logic             w_stray;
    logic             w_rsp_take;
    obi_payload_t     w_push_data;
    obi_payload_t     w_head;

    // Grant depends on registered state only, never on the core's request.
    assign w_core_gnt  = !w_fifo_full && (r_cnt < CNT_MAX);
    assign w_core_hs   = core_req_i.req && w_core_gnt;
    assign w_bus_hs    = !w_fifo_empty && bus_resp_i.gnt;
    assign w_stray     = bus_resp_i.rvalid && (r_cnt == '0) && !r_rvalid;
    assign w_rsp_take  = bus_resp_i.rvalid && !w_stray;
    assign w_push_data = '{we: core_req_i.we, be: core_req_i.be,
                           addr: core_req_i.addr, wdata: core_req_i.wdata};

    obi_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_core_hs),
        .pop_i   (w_bus_hs),
        .wdata_i (w_push_data),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // In-flight counter: +1 per accepted request, -1 per response to the core.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_core_hs, r_rvalid})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Response register; unexpected responses are dropped and flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_stray  <= 1'b0;
        end else begin
            r_rvalid <= w_rsp_take;
            r_stray  <= w_stray;
            if (w_rsp_take) begin
                r_rdata <= bus_resp_i.rdata;
            end
        end
    end

    // Output assembly; an idle bus port drives all-zero request fields.
    always_comb begin
        core_resp_o        = '0;
        core_resp_o.gnt    = w_core_gnt;
        core_resp_o.rvalid = r_rvalid;
        core_resp_o.rdata  = r_rdata;
        bus_req_o          = '0;
        if (!w_fifo_empty) begin
            bus_req_o = obi_issue(w_head);
        end else begin
            bus_req_o = '0;
        end
    end

    assign outstanding_o  = r_cnt;
    assign stray_rvalid_o = r_stray;

endmodule

// File: tb/tb_obi_data_slice.sv
// Randomized scoreboard bench for obi_data_slice: a transaction-level model
// predicts grants, bus requests, responses and the in-flight count.
module tb_obi_data_slice;
    import obi_pkg::*;
    import core_v_mini_mcu_pkg::*;

    localparam int DEPTH = int'(OBI_SLICE_REQ_DEPTH);
    localparam int MAXO  = int'(OBI_SLICE_MAX_OUTSTANDING);
    localparam int CW    = $clog2(MAXO + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    obi_req_t      core_req_i;
    obi_resp_t     core_resp_o;
    obi_req_t      bus_req_o;
    obi_resp_t     bus_resp_i;
    logic [CW-1:0] outstanding_o;
    logic          stray_rvalid_o;

    obi_data_slice dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .core_req_i     (core_req_i),
        .core_resp_o    (core_resp_o),
        .bus_req_o      (bus_req_o),
        .bus_resp_i     (bus_resp_i),
        .outstanding_o  (outstanding_o),
        .stray_rvalid_o (stray_rvalid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    bit mon_en = 0, drv_on = 0, rv_hold = 0, inject_stray = 0, fixed_rdata = 0;
    int req_pct = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
    int unsigned cyc = 0, last_due = 0;

    obi_payload_t dir_q[$];
    obi_payload_t bus_q[$];
    logic [31:0]  exp_rdata[$];
    int unsigned  pend_due[$];
    logic [31:0]  pend_data[$];

    // Transaction-level model state
    int m_occ = 0, m_out = 0;
    bit m_rv_pend = 0, m_stray_pend = 0, m_rdata_zero = 1;
    int hs_cnt = 0, ngnt_cnt = 0, dut_stray_cnt = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obi_payload_t rand_payload();
        obi_payload_t p;
        p.we    = 1'($urandom_range(1, 0));
        p.be    = 4'($urandom_range(15, 1));
        p.addr  = $urandom & 32'hFFFF_FFFC;
        p.wdata = $urandom;
        return p;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #3;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((m_occ != 0 || m_out != 0 || m_rv_pend || core_req_i.req) && k < 200) begin
            step(1);
            k++;
        end
        chk("drain_in_time", 72'(k < 200), 72'(1));
    endtask

    // Core driver: holds each request stable until it is granted.
    initial begin : driver
        bit last_hs;
        last_hs    = 1'b0;
        core_req_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                core_req_i = '0;
            end else if (!core_req_i.req || last_hs) begin
                if (dir_q.size() > 0) core_req_i = obi_issue(dir_q.pop_front());
                else if (drv_on && int'($urandom_range(99, 0)) < req_pct) core_req_i = obi_issue(rand_payload());
                else core_req_i = '0;
            end
            last_hs = core_req_i.req && core_resp_o.gnt;
        end
    end

    // Bus responder: random grants, in-order responses after a latency.
    initial begin : responder
        int unsigned due;
        logic [31:0] data;
        bus_resp_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            cyc++;
            bus_resp_i = '0;
            if (rst_i) begin
                pend_due.delete();
                pend_data.delete();
                last_due = cyc;
            end else begin
                if (inject_stray) begin
                    bus_resp_i.rvalid = 1'b1;
                    bus_resp_i.rdata  = $urandom;
                    inject_stray      = 1'b0;
                end else if (!rv_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus_resp_i.rvalid = 1'b1;
                    bus_resp_i.rdata  = pend_data.pop_front();
                    void'(pend_due.pop_front());
                end
                bus_resp_i.gnt = (int'($urandom_range(99, 0)) < gnt_pct);
                if (bus_req_o.req && bus_resp_i.gnt) begin
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    data = fixed_rdata ? 32'hDEAD_BEEF : $urandom;
                    pend_due.push_back(due);
                    pend_data.push_back(data);
                    exp_rdata.push_back(data);
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model, then advances the model.
    always @(negedge clk_i) begin : monitor
        bit exp_gnt, stray, new_rv;
        obi_payload_t act_p;
        if (mon_en) begin
            exp_gnt = (m_occ < DEPTH) && (m_out < MAXO);
            chk("core_gnt", 72'(core_resp_o.gnt), 72'(exp_gnt));
            if (!core_resp_o.gnt) ngnt_cnt++;
            if (stray_rvalid_o) dut_stray_cnt++;
            chk("outstanding", 72'(outstanding_o), 72'(m_out));
            chk("core_rvalid", 72'(core_resp_o.rvalid), 72'(m_rv_pend));
            chk("stray_rvalid", 72'(stray_rvalid_o), 72'(m_stray_pend));
            if (m_rv_pend) begin
                if (exp_rdata.size() == 0) chk("rdata_queue_nonempty", 72'(0), 72'(1));
                else chk("core_rdata", 72'(core_resp_o.rdata), 72'(exp_rdata.pop_front()));
            end else if (m_rdata_zero) begin
                chk("core_rdata_reset", 72'(core_resp_o.rdata), 72'(0));
            end
            if (m_occ == 0) begin
                chk("bus_idle", 72'(bus_req_o), 72'(0));
            end else begin
                chk("bus_req", 72'(bus_req_o.req), 72'(1));
                act_p = '{we: bus_req_o.we, be: bus_req_o.be, addr: bus_req_o.addr, wdata: bus_req_o.wdata};
                chk("bus_payload", 72'(act_p), 72'(bus_q[0]));
            end
            if (rst_i) begin
                m_occ = 0; m_out = 0; m_rv_pend = 0; m_stray_pend = 0; m_rdata_zero = 1;
                bus_q.delete();
                exp_rdata.delete();
            end else begin
                stray  = bus_resp_i.rvalid && (m_out == 0) && !m_rv_pend;
                new_rv = bus_resp_i.rvalid && !stray;
                if (bus_resp_i.rvalid) m_rdata_zero = 0;
                if (m_occ != 0 && bus_resp_i.gnt) begin
                    void'(bus_q.pop_front());
                    m_occ--;
                end
                if (core_req_i.req && exp_gnt) begin
                    bus_q.push_back('{we: core_req_i.we, be: core_req_i.be,
                                      addr: core_req_i.addr, wdata: core_req_i.wdata});
                    m_occ++;
                    m_out++;
                    hs_cnt++;
                end
                if (m_rv_pend) m_out--;
                m_rv_pend    = new_rv;
                m_stray_pend = stray;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #3;
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Single read, rdata DEADBEEF, two-cycle bus latency
        gnt_pct = 100; lat_min = 2; lat_max = 2; fixed_rdata = 1;
        dir_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_0180, wdata: 32'h0});
        step(8);
        chk("single_rd_rdata", 72'(core_resp_o.rdata), 72'(32'hDEAD_BEEF));
        fixed_rdata = 0;
        drain();

        // Eight back-to-back writes, rvalid one cycle after grant
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++)
            dir_q.push_back('{we: 1'b1, be: 4'($urandom_range(15, 1)),
                              addr: 32'h0000_1000 + 32'(i * 4), wdata: $urandom});
        hs_cnt = 0; ngnt_cnt = 0;
        step(10);
        chk("b2b_handshakes", 72'(hs_cnt), 72'(8));
        chk("b2b_gnt_low_cycles", 72'(ngnt_cnt), 72'(0));
        drain();

        // Bus withholds grant for 10 cycles
        gnt_pct = 0; req_pct = 100; drv_on = 1; hs_cnt = 0;
        step(10);
        chk("nognt_handshakes", 72'(hs_cnt), 72'(DEPTH));
        chk("nognt_core_gnt", 72'(core_resp_o.gnt), 72'(0));
        drv_on = 0; gnt_pct = 100;
        drain();

        // Bus withholds responses: cap on in-flight transactions
        rv_hold = 1; drv_on = 1; hs_cnt = 0;
        step(12);
        chk("maxout_handshakes", 72'(hs_cnt), 72'(MAXO));
        chk("maxout_count", 72'(outstanding_o), 72'(MAXO));
        drv_on = 0; rv_hold = 0;
        drain();

        // Reset with one in flight and two queued, then a stray response
        rv_hold = 1;
        dir_q.push_back(rand_payload());
        step(4);
        chk("pre_rst_inflight", 72'(outstanding_o), 72'(1));
        gnt_pct = 0;
        dir_q.push_back(rand_payload());
        dir_q.push_back(rand_payload());
        step(4);
        chk("pre_rst_outstanding", 72'(outstanding_o), 72'(3));
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("rst_outstanding", 72'(outstanding_o), 72'(0));
        chk("rst_bus_req", 72'(bus_req_o), 72'(0));
        chk("rst_core_gnt", 72'(core_resp_o.gnt), 72'(1));
        chk("rst_core_rvalid", 72'(core_resp_o.rvalid), 72'(0));
        chk("rst_core_rdata", 72'(core_resp_o.rdata), 72'(0));
        rv_hold = 0; gnt_pct = 100;
        step(2);
        dut_stray_cnt = 0;
        inject_stray  = 1;
        step(5);
        chk("stray_pulses", 72'(dut_stray_cnt), 72'(1));
        chk("stray_outstanding", 72'(outstanding_o), 72'(0));
        drain();

        // Randomized traffic
        drv_on = 1;
        for (int blk = 0; blk < 6; blk++) begin
            req_pct = int'($urandom_range(100, 30));
            gnt_pct = int'($urandom_range(100, 20));
            lat_min = 1;
            lat_max = int'($urandom_range(5, 1));
            step(400);
        end
        drv_on = 0; gnt_pct = 100;
        drain();
        chk("end_bus_queue_empty", 72'(bus_q.size()), 72'(0));
        chk("end_rdata_queue_empty", 72'(exp_rdata.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
